// File: rtl/mux6_arb_pkg.sv
// Shared types and constants for the 6-input round-robin mux arbiter.
package mux6_arb_pkg;

  localparam int unsigned NUM_REQ = 6;
  localparam int unsigned SEL_W   = 3;

  localparam logic [SEL_W-1:0] LAST_RESET = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    RELEASE
  } arb_state_t;

  // One-hot grant vector for a requester index.
  function automatic logic [NUM_REQ-1:0] sel_onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_pick6.sv
// Combinational round-robin search: first set request at or after start, wrapping 5 -> 0.
module rr_pick6
  import mux6_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   start,
  output logic [SEL_W-1:0]   winner,
  output logic               found
);

  // Walk the six positions from start, keeping only the first hit.
  always_comb begin
    int unsigned k;
    winner = '0;
    found  = 1'b0;
    k      = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      k = (32'(start) + i) % NUM_REQ;
      if (!found && req[SEL_W'(k)]) begin
        winner = SEL_W'(k);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux6_arbiter.sv
// Round-robin arbiter driving the select of the shared 6:1 mux.
// Optional hold timeout: define MUX6_ARB_TIMEOUT_EN to force a release after MAX_HOLD grant cycles.
module mux6_arbiter
  import mux6_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 15
) (
  input  logic               Clk,
  input  logic               Reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   select,
  output logic               busy
);

  // Reject out-of-range hold limits at elaboration.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux6_arbiter: MAX_HOLD must be 1..255");
  end

  arb_state_t         state_q, state_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [SEL_W-1:0]   select_d;
  logic               busy_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [SEL_W-1:0]   start_c;
  logic [SEL_W-1:0]   winner_c;
  logic               found_c;
  logic               timeout_c;

  // Search begins one past the last winner, wrapping after index 5.
  assign start_c = (last_q >= SEL_W'(NUM_REQ - 1)) ? '0 : last_q + SEL_W'(1);

  rr_pick6 u_pick (
    .req    (req),
    .start  (start_c),
    .winner (winner_c),
    .found  (found_c)
  );

`ifdef MUX6_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD + 1);

  logic [HOLD_W-1:0] hold_q, hold_d;

  // Count grant cycles; zero outside GRANT so every new grant starts fresh, saturate at MAX_HOLD.
  always_comb begin
    hold_d = hold_q;
    if (state_q != GRANT) begin
      hold_d = '0;
    end else if (hold_q != HOLD_W'(MAX_HOLD)) begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  assign timeout_c = (state_q == GRANT) && (hold_q == HOLD_W'(MAX_HOLD - 1));

  // Hold counter register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  assign timeout_c = 1'b0;
`endif

  // Next state and next registered outputs.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant;
    select_d = select;
    last_d   = last_q;
    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (found_c) begin
          state_d  = GRANT;
          grant_d  = sel_onehot(winner_c);
          select_d = winner_c;
          last_d   = winner_c;
        end
      end
      GRANT: begin
        grant_d = sel_onehot(select);
        if (!req[select] || timeout_c) begin
          state_d = RELEASE;
          grant_d = '0;
        end
      end
      RELEASE: begin
        grant_d = '0;
        if (found_c) begin
          state_d  = GRANT;
          grant_d  = sel_onehot(winner_c);
          select_d = winner_c;
          last_d   = winner_c;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
    busy_d = |grant_d;
  end

  // State and output registers; reset clears the grant without waiting for a clock.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      grant   <= '0;
      select  <= '0;
      busy    <= 1'b0;
      last_q  <= LAST_RESET;
    end else begin
      state_q <= state_d;
      grant   <= grant_d;
      select  <= select_d;
      busy    <= busy_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: doc/mux6_arbiter.md
# mux6_arbiter

Round-robin arbiter that shares the 6:1 single-bit mux between six requesting sources and drives its 3-bit `select`. Sources raise a request and hold it while they need the mux output. The arbiter grants one source at a time, steers `select` to that source's index, and rotates fairly among the remaining requesters. It sits directly in front of the mux in the final-project datapath and is the only driver of the mux select.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive grant cycles per requester. Legal range is 1..255. Effective only with the timeout feature (see Configuration).
- `Clk` input 1: system clock. All state changes on the rising edge.
- `Reset_n` input 1: reset, asynchronous and active-low.
- `req` input 6: request vector. Bit i belongs to mux input i.
- `grant` output 6: one-hot grant, registered. At most one bit is high.
- `select` output 3: mux select, registered. Only values 0..5 are ever driven.
- `busy` output 1: high while any grant is active. Equals the OR of `grant`.

## Operation
- The FSM has three states: IDLE, GRANT, RELEASE.
- **IDLE**
  - `grant` = 0.
  - If `req` != 0, pick a winner, load it, and go to GRANT.
  - Otherwise stay in IDLE.
- **GRANT**
  - `grant[cur]` = 1 and `select` = cur.
  - Go to RELEASE when `req[cur]` = 0.
  - With the timeout feature, also go to RELEASE when the hold count reaches `MAX_HOLD`.
  - `req` changes on other bits are ignored while in GRANT.
- **RELEASE**
  - A one-cycle bubble: `grant` = 0 and `select` holds cur.
  - If `req` != 0, pick a winner and go to GRANT. Otherwise go to IDLE.
- **Winner selection**
  - Search starts at `last`+1 (mod 6) and takes the first set `req` bit found.
  - `last` is updated to the winner when the winner is loaded.
  - Wrap-around: after index 5 the search continues at index 0.
  - A sole requester is re-granted after its RELEASE bubble.
- **Reset values**
  - `grant` = 0, `select` = 3'd0, `busy` = 0, state = IDLE.
  - `last` = 3'd5, so the first search begins at index 0.
  - Hold counter = 0.
- **Width rules**
  - `select` is the 3-bit binary form of cur; 6 and 7 are never produced.
  - The hold counter is `$clog2(MAX_HOLD+1)` bits and saturates; it never wraps.
- **Simultaneous events**
  - If `req[cur]` drops in the same cycle the timeout fires, there is a single RELEASE cycle.
  - Requests that arrive during RELEASE take part in that cycle's selection.

## Timing
- **Grant latency:** `req` is sampled high at edge k in IDLE, and `grant`/`select` are valid after edge k. That is one edge of latency.
- **Release latency:** `req[cur]` is sampled low at edge k, and `grant` is 0 after edge k.
- **Handover:** the next requester is granted after edge k+1. There is always at least one dead cycle between two grants.
- **Select timing:** `select` changes only on the edge that asserts a new grant. It is therefore stable for the whole grant and for the following bubble.
- **Timeout:** the counter clears on entry to GRANT and increments on each GRANT cycle. The grant is high for exactly `MAX_HOLD` cycles when `req` stays asserted.
- **Reset mid-operation:** deasserting `Reset_n` clears `grant` immediately, without waiting for `Clk`. Operation resumes from IDLE on the first edge after `Reset_n` rises.

## Configuration
- Macro: `MUX6_ARB_TIMEOUT_EN`.
- **Defined:** the hold counter and the forced RELEASE at `MAX_HOLD` are present.
- **Undefined:** the counter logic is omitted. A grant lasts until `req[cur]` drops, so one requester can hold the mux indefinitely. `MAX_HOLD` is then ignored.

## Structure
- **Shared package `mux6_arb_pkg`:**
  - `NUM_REQ` = 6.
  - `SEL_W` = 3.
  - State enum `arb_state_t` {IDLE, GRANT, RELEASE}.
  - Constant `LAST_RESET` = 3'd5.
- **Sub-module `rr_pick6`:** purely combinational.
  - Inputs: `req[5:0]` and start index `[2:0]`.
  - Outputs: `winner[2:0]` and `found`.
  - Instantiated once. It is unit-testable on its own.

## Test plan
- **Reset defaults:** hold `Reset_n` low, with `req`=6'b111111 -> `grant`=0, `select`=0, `busy`=0. Release reset -> the first grant is `grant`=6'b000001, `select`=0.
- **Full rotation:** hold `req`=6'b111111, with timeout enabled and `MAX_HOLD`=2 -> grants go to indices 0,1,2,3,4,5,0 in order. Each grant lasts exactly 2 cycles with a 1-cycle bubble between grants.
- **Wrap and skip:** after `last`=4, apply `req`=6'b000101 -> index 0 is granted (not 2). Then after release, index 2 is granted.
- **Sole requester timeout:** hold `req`=6'b001000 with `MAX_HOLD`=3 -> `grant[3]` is high for 3 cycles, low for 1, high for 3, repeating. `select` stays 3 throughout.
- **No timeout build:** with `MUX6_ARB_TIMEOUT_EN` undefined, hold `req[1]` for 100 cycles with `req[4]` also high -> `grant[1]` is held for all 100 cycles. `req[1]` drops -> bubble, then `grant[4]` and `select`=4.
- **Async reset mid-grant:** pulse `Reset_n` low between clock edges during a `grant[2]` -> `grant` goes to 0 before the next edge. After reset, `req[2]` still high -> `grant[2]` one edge later.
